text_mem_ctrl: RTL
==================

Name: text_mem_ctrl

Overview:
Sequencing controller for the single-port text memory (s_mem: address, clock, data, wren, q; synchronous read, q valid the cycle after the address is clocked).
- Loads a message into the memory from a byte-write handshake.
- Streams the stored message back out over a valid/ready byte interface for the transmit source.
- Owns the memory's address, data and write-enable, so loading and reading never contend.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, byte width
DEPTH, 16, maximum message length in bytes (must be <= 2^ADDR_W)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
load_start  in  1  pulse: clear message, enter LOAD
wr_valid  in  1  write byte offered
wr_data  in  DATA_W  byte to store
wr_ready  out  1  controller accepts byte this cycle
load_done  in  1  pulse: end of message load
read_start  in  1  pulse: stream message from address 0
rd_valid  out  1  rd_data holds a message byte
rd_data  out  DATA_W  output byte (registered)
rd_ready  in  1  consumer accepts byte
rd_last  out  1  current rd_data is final byte
busy  out  1  state != IDLE
msg_len  out  ADDR_W+1  bytes currently stored
mem_address  out  ADDR_W  to s_mem address
mem_data  out  DATA_W  to s_mem data
mem_wren  out  1  to s_mem wren
mem_q  in  DATA_W  from s_mem q

Behaviour:
- Reset (reset=0, async):
  - State = IDLE.
  - wr_ptr, rd_ptr, msg_len, rd_data = 0.
  - rd_valid, rd_last, busy, wr_ready, mem_wren = 0.
  - Takes effect immediately, including mid-load or mid-read; stored RAM contents are not cleared.
- States: IDLE, LOAD, RD_ADDR, RD_CAP, RD_OUT.
- IDLE:
  - load_start -> LOAD; wr_ptr=0, msg_len=0.
  - Else read_start with msg_len>0 -> RD_ADDR; rd_ptr=0.
  - read_start with msg_len==0 is ignored.
  - load_start has priority when both arrive in the same cycle.
- LOAD:
  - wr_ready = (msg_len < DEPTH), combinational.
  - Write on wr_valid & wr_ready in the same cycle:
    - mem_wren=1, mem_address=wr_ptr, mem_data=wr_data.
    - At the edge: wr_ptr+1, msg_len+1.
  - When msg_len == DEPTH: wr_ready=0; further bytes are not written.
  - load_done -> IDLE. A write in the same cycle is still performed and counted.
  - load_start and read_start are ignored in LOAD.
- Read sequencing:
  - RD_ADDR: mem_address=rd_ptr for one cycle -> RD_CAP.
  - RD_CAP: mem_q valid; rd_data <= mem_q at the edge; rd_last <= (rd_ptr == msg_len-1) -> RD_OUT.
  - RD_OUT: rd_valid=1; rd_data and rd_last held stable until rd_ready=1.
  - On handshake (rd_valid & rd_ready):
    - If rd_last: -> IDLE; rd_valid and rd_last cleared.
    - Else: rd_ptr+1 -> RD_ADDR.
  - load_start, read_start and load_done are ignored during read states.
- Read latency: read_start sampled at edge N gives rd_valid=1 in the cycle after edge N+2 (three cycles). Throughput is one byte per three cycles with rd_ready held high.
- Memory mux:
  - mem_address = wr_ptr in LOAD, else rd_ptr.
  - mem_data = wr_data at all times.
  - mem_wren = 1 only on an accepted LOAD write.
- msg_len persists across reads; only load_start or reset clear it. Repeated read_start replays the same message.
- Pointer widths: wr_ptr and rd_ptr are ADDR_W+1 internally. mem_address takes the low ADDR_W bits. Pointers never exceed DEPTH-1 when driving memory, so there is no wrap-around.

Test Plan:
1. Reset, load_start, write 0x48,0x69,0x21 with wr_valid=1, then load_done -> mem_wren pulses at addresses 0,1,2 with those data; msg_len=3; busy=0 afterwards.
2. After test 1, read_start with rd_ready=1 -> rd_valid first high 3 cycles after read_start; bytes 0x48,0x69,0x21 at 3-cycle spacing; rd_last=1 only on 0x21; then IDLE, busy=0.
3. Backpressure: hold rd_ready=0 for 5 cycles during the second byte -> rd_data stays 0x69, rd_valid stays 1, mem_address stays 1; resumes on rd_ready=1.
4. Full: DEPTH=16, offer 17 bytes continuously -> 16 writes at addresses 0..15; wr_ready=0 from the 17th cycle; msg_len=16; the 17th byte is never written.
5. Corner cases:
   - read_start with msg_len=0 -> stays IDLE, rd_valid=0.
   - load_start and read_start in the same cycle -> LOAD, msg_len=0.
   - load_done coincident with a write -> byte is counted.
6. Assert reset=0 during RD_OUT -> rd_valid, busy and msg_len go to 0 immediately. After release, read_start is ignored until a new load.

Source files
------------

// File: rtl/text_mem_ctrl.sv
// Sequencing controller for a single-port text memory: loads a message from a
// byte-write handshake and streams it back out over a valid/ready byte port.
module text_mem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              load_done,
    input  logic              read_start,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              busy,
    output logic [ADDR_W:0]   msg_len,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [2:0]        state_dbg
);

    // Handshakes: a byte moves when valid and ready are both high at a rising
    // edge; valid never waits on ready, and data/last hold until the transfer.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RD_ADDR = 3'd2,
        RD_CAP  = 3'd3,
        RD_OUT  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state, state_nxt;
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic            wr_fire, rd_fire;

    assign wr_ready    = (state == LOAD) && (msg_len < DEPTH_L);
    assign wr_fire     = wr_valid && wr_ready;
    assign rd_valid    = (state == RD_OUT);
    assign rd_fire     = rd_valid && rd_ready;
    assign busy        = (state != IDLE);
    assign mem_address = (state == LOAD) ? wr_ptr[ADDR_W-1:0] : rd_ptr[ADDR_W-1:0];
    assign mem_data    = wr_data;
    assign mem_wren    = wr_fire;
    assign state_dbg   = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start)
                    state_nxt = LOAD;
                else if (read_start && (msg_len != '0))
                    state_nxt = RD_ADDR;
            end
            LOAD:    if (load_done) state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_CAP;
            RD_CAP:  state_nxt = RD_OUT;
            RD_OUT:  if (rd_fire) state_nxt = rd_last ? IDLE : RD_ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM contents survive reset; only the pointers and message length clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            msg_len <= '0;
            rd_data <= '0;
            rd_last <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        wr_ptr  <= '0;
                        msg_len <= '0;
                    end else if (read_start && (msg_len != '0)) begin
                        rd_ptr <= '0;
                    end
                end
                LOAD: begin
                    if (wr_fire) begin
                        wr_ptr  <= wr_ptr + PTR_ONE;
                        msg_len <= msg_len + PTR_ONE;
                    end
                end
                RD_CAP: begin
                    rd_data <= mem_q;
                    rd_last <= (rd_ptr == (msg_len - PTR_ONE));
                end
                RD_OUT: begin
                    if (rd_fire) begin
                        if (rd_last)
                            rd_last <= 1'b0;
                        else
                            rd_ptr <= rd_ptr + PTR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
